mult_alu_seq: RTL

MULT_ALU_SEQ -- requirements
Module: mult_alu_seq

---
 rtl/mult_alu_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mult_alu_seq.sv
// mult_alu_seq: sequential ALU with a shift-add multiplier.
//
// An operation is accepted in IDLE when start=1. A, B and ALUControl are
// latched on that edge and are not disturbed until the operation completes.
// ADD/SUB/AND/OR and the reserved codes take one EXEC cycle. MUL
// (ALUControl=100) spends N cycles in MUL, retiring one multiplier bit per
// edge. Every operation then spends one DONE cycle, during which done=1.
//
// Handshake: a request is taken on a rising edge where start=1 and the FSM is
// in IDLE (busy=0). start is ignored while busy=1, including the DONE cycle.
// done is a one-cycle strobe. Result, ResultHi and the flags are valid while
// done=1 and hold until the next operation completes.
//
// Ports:
//   clk        : clock; all state updates on the rising edge
//   reset      : asynchronous active-high reset
//   start      : operation request
//   A, B       : N-bit operands
//   ALUControl : 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101-111 reserved
//   Result     : low N bits of the result
//   ResultHi   : high N bits of the MUL product; 0 for every other op
//   V, C, Neg, Z : overflow, carry, negative and zero flags
//   busy       : FSM is not in IDLE
//   done       : completion strobe (FSM is in DONE)
//   state      : FSM state for observation (0 IDLE, 1 EXEC, 2 MUL, 3 DONE)
module mult_alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   ALUControl,
  output logic [N-1:0] Result,
  output logic [N-1:0] ResultHi,
  output logic         V,
  output logic         C,
  output logic         Neg,
  output logic         Z,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam int         CW     = $clog2(N) + 1;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, b_q;
  logic [2:0]     op_q;
  logic [N-1:0]   m_hi, m_lo;   // partial product high half / shifting multiplier
  logic [CW-1:0]  cnt;
  logic           mul_last;

  logic [N-1:0]   b_eff;
  logic [N:0]     add_full;
  logic [N-1:0]   alu_res;
  logic           alu_v, alu_c;

  logic [N:0]     mul_sum;
  logic [N-1:0]   mul_hi_nx, mul_lo_nx;

  assign state    = state_q;
  assign mul_last = (cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = (ALUControl == OP_MUL) ? MUL : EXEC;
      EXEC: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      MUL: begin
        busy = 1'b1;
        if (mul_last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle ALU on the latched operands. SUB is A + ~B + 1, so the
  // overflow test compares A against the inverted operand actually added.
  always_comb begin
    b_eff    = (op_q == OP_SUB) ? ~b_q : b_q;
    add_full = {1'b0, a_q} + {1'b0, b_eff} + {{N{1'b0}}, (op_q == OP_SUB)};
    alu_res  = '0;
    alu_v    = 1'b0;
    alu_c    = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        alu_res = add_full[N-1:0];
        alu_c   = add_full[N];
        alu_v   = (a_q[N-1] == b_eff[N-1]) && (add_full[N-1] != a_q[N-1]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add A when the current multiplier bit is set, then
  // shift {sum, multiplier} right by one. The sum's carry is the new MSB of
  // the high half, so no product bit is lost.
  always_comb begin
    mul_sum   = {1'b0, m_hi} + (m_lo[0] ? {1'b0, a_q} : {(N+1){1'b0}});
    mul_hi_nx = mul_sum[N:1];
    mul_lo_nx = {mul_sum[0], m_lo[N-1:1]};
  end

  // Operand latches, multiplier datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      m_hi     <= '0;
      m_lo     <= '0;
      cnt      <= '0;
      Result   <= '0;
      ResultHi <= '0;
      V        <= 1'b0;
      C        <= 1'b0;
      Neg      <= 1'b0;
      Z        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q  <= A;
          b_q  <= B;
          op_q <= ALUControl;
          m_hi <= '0;
          m_lo <= B;
          cnt  <= '0;
        end
        EXEC: begin
          Result   <= alu_res;
          ResultHi <= '0;
          V        <= alu_v;
          C        <= alu_c;
          Neg      <= alu_res[N-1];
          Z        <= (alu_res == '0);
        end
        MUL: begin
          m_hi <= mul_hi_nx;
          m_lo <= mul_lo_nx;
          cnt  <= cnt + 1'b1;
          if (mul_last) begin
            Result   <= mul_lo_nx;
            ResultHi <= mul_hi_nx;
            V        <= (mul_hi_nx != '0);
            C        <= 1'b0;
            Neg      <= mul_hi_nx[N-1];
            Z        <= ({mul_hi_nx, mul_lo_nx} == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
